// File: rtl/ucontrol_sequencer.sv
// Microcoded control sequencer for the ARC-subset datapath.
// Runs the fetch/decode/execute/PC-update loop. It drives the A/B/C bus
// codes and selectors, the ALU selection, the clear selection and the
// BUS_C source. It also holds the {N,Z,V,C} condition codes.
// Ports:
//   uCONTROL_CLOCK_50 / uCONTROL_RESET_InHigh : clock, synchronous active-high reset
//   uCONTROL_Registro_IR_InBUS                : current IR contents
//   uCONTROL_*_InLow                          : ALU flags, active-low
//   uCONTROL_memack_InHigh / memreq_OutHigh   : instruction-read handshake
//   uCONTROL_busCsource_Out                   : 0 = ALU result, 1 = memory data on BUS_C
//   uCONTROL_BUS_CONTROL_* / BUS_SELECTOR_*   : register codes and code/IR-field selectors
//   uCONTROL_aluselection_OutBUS              : ALU operation
//   uCONTROL_decoderclearselection_OutBUS     : clear target (always idle)
//   uCONTROL_psr_OutBUS                       : {N,Z,V,C}, active-high
//   uCONTROL_illegal_OutHigh                  : pulses in DECODE on an unsupported instruction
module ucontrol_sequencer #(
  parameter int unsigned DATAWIDTH_BUS           = 32,
  parameter int unsigned DATA_BUS_CONTROL        = 6,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4
) (
  input  logic                               uCONTROL_CLOCK_50,
  input  logic                               uCONTROL_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]           uCONTROL_Registro_IR_InBUS,
  input  logic                               uCONTROL_overflow_InLow,
  input  logic                               uCONTROL_carry_InLow,
  input  logic                               uCONTROL_negative_InLow,
  input  logic                               uCONTROL_zero_InLow,
  input  logic                               uCONTROL_memack_InHigh,
  output logic                               uCONTROL_memreq_OutHigh,
  output logic                               uCONTROL_busCsource_Out,
  output logic [DATA_BUS_CONTROL-1:0]        uCONTROL_BUS_CONTROL_A_OutBUS,
  output logic [DATA_BUS_CONTROL-1:0]        uCONTROL_BUS_CONTROL_B_OutBUS,
  output logic [DATA_BUS_CONTROL-1:0]        uCONTROL_BUS_CONTROL_C_OutBUS,
  output logic                               uCONTROL_BUS_SELECTOR_A_Out,
  output logic                               uCONTROL_BUS_SELECTOR_B_Out,
  output logic                               uCONTROL_BUS_SELECTOR_C_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] uCONTROL_aluselection_OutBUS,
  output logic [3:0]                         uCONTROL_decoderclearselection_OutBUS,
  output logic [3:0]                         uCONTROL_psr_OutBUS,
  output logic                               uCONTROL_illegal_OutHigh
);

  localparam int unsigned CW = DATA_BUS_CONTROL;
  localparam int unsigned AW = DATAWIDTH_ALU_SELECTION;

  localparam logic [CW-1:0] A_PC    = CW'(6);
  localparam logic [CW-1:0] B_IR    = CW'(7);
  localparam logic [CW-1:0] B_TEMP0 = CW'(8);
  localparam logic [CW-1:0] C_PC    = CW'(5);
  localparam logic [CW-1:0] C_IR    = CW'(6);
  localparam logic [CW-1:0] C_NONE  = CW'(15);

  localparam logic [AW-1:0] ALU_PASSA  = AW'(0);
  localparam logic [AW-1:0] ALU_ADD    = AW'(1);
  localparam logic [AW-1:0] ALU_AND    = AW'(2);
  localparam logic [AW-1:0] ALU_OR     = AW'(3);
  localparam logic [AW-1:0] ALU_ORN    = AW'(4);
  localparam logic [AW-1:0] ALU_SRL    = AW'(5);
  localparam logic [AW-1:0] ALU_INC4   = AW'(6);
  localparam logic [AW-1:0] ALU_BRADDR = AW'(7);

  localparam logic [3:0] CLEAR_NONE = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_PCINC
  } state_t;

  state_t          state, next_state;
  logic [3:0]      psr;
  logic [CW-1:0]   a_q, b_q, c_q, nx_a, nx_b, nx_c;
  logic            sel_a_q, sel_b_q, sel_c_q, nx_sel_a, nx_sel_b, nx_sel_c;
  logic [AW-1:0]   alu_q, nx_alu, alu_op;
  logic            memreq_q, busc_q, nx_memreq, nx_busc;
  logic            legal_alu, is_branch, taken;

  // IR fields; rd/rs1/rs2 are routed by the datapath through the selectors.
  logic [1:0] op;
  logic [5:0] op3;
  logic [2:0] op2;
  logic [3:0] cond;
  logic       imm;
  logic       unused_ir;

  assign op        = uCONTROL_Registro_IR_InBUS[31:30];
  assign op3       = uCONTROL_Registro_IR_InBUS[24:19];
  assign op2       = uCONTROL_Registro_IR_InBUS[24:22];
  assign cond      = uCONTROL_Registro_IR_InBUS[28:25];
  assign imm       = uCONTROL_Registro_IR_InBUS[13];
  assign unused_ir = ^{uCONTROL_Registro_IR_InBUS[29], uCONTROL_Registro_IR_InBUS[18:14],
                       uCONTROL_Registro_IR_InBUS[12:0]};

  // Instruction decode: ALU op legality and branch condition on current PSR.
  always_comb begin
    alu_op    = ALU_PASSA;
    legal_alu = 1'b0;
    taken     = 1'b0;
    case (op3)
      6'b000000, 6'b010000: begin alu_op = ALU_ADD; legal_alu = 1'b1; end
      6'b000001, 6'b010001: begin alu_op = ALU_AND; legal_alu = 1'b1; end
      6'b000010, 6'b010010: begin alu_op = ALU_OR;  legal_alu = 1'b1; end
      6'b000110, 6'b010110: begin alu_op = ALU_ORN; legal_alu = 1'b1; end
      6'b100110:            begin alu_op = ALU_SRL; legal_alu = 1'b1; end
      default: ;
    endcase
    if (op != 2'b10 || imm) legal_alu = 1'b0;
    is_branch = (op == 2'b00) && (op2 == 3'b010);
    case (cond)
      4'b1000: taken = 1'b1;
      4'b0001: taken = psr[2];
      4'b0101: taken = psr[0];
      4'b0110: taken = psr[3];
      4'b0111: taken = psr[1];
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (uCONTROL_memack_InHigh) next_state = S_DECODE;
      S_DECODE: begin
        if (legal_alu)              next_state = S_EXEC;
        else if (is_branch && taken) next_state = S_BRANCH;
        else                         next_state = S_PCINC;
      end
      S_EXEC:   next_state = S_PCINC;
      S_BRANCH: next_state = S_FETCH;
      S_PCINC:  next_state = S_FETCH;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, so they are registered yet Moore-exact.
  always_comb begin
    nx_a      = A_PC;
    nx_b      = B_TEMP0;
    nx_c      = C_NONE;
    nx_sel_a  = 1'b1;
    nx_sel_b  = 1'b1;
    nx_sel_c  = 1'b1;
    nx_alu    = ALU_PASSA;
    nx_memreq = 1'b0;
    nx_busc   = 1'b0;
    case (next_state)
      S_FETCH:  begin nx_memreq = 1'b1; nx_busc = 1'b1; nx_c = C_IR; end
      S_EXEC:   begin nx_sel_a = 1'b0; nx_sel_b = 1'b0; nx_sel_c = 1'b0; nx_alu = alu_op; end
      S_BRANCH: begin nx_b = B_IR; nx_alu = ALU_BRADDR; nx_c = C_PC; end
      S_PCINC:  begin nx_alu = ALU_INC4; nx_c = C_PC; end
      default: ;
    endcase
  end

  // State, PSR and output registers.
  always_ff @(posedge uCONTROL_CLOCK_50) begin
    if (uCONTROL_RESET_InHigh) begin
      state    <= S_IDLE;
      psr      <= 4'b0000;
      a_q      <= A_PC;
      b_q      <= B_TEMP0;
      c_q      <= C_NONE;
      sel_a_q  <= 1'b1;
      sel_b_q  <= 1'b1;
      sel_c_q  <= 1'b1;
      alu_q    <= ALU_PASSA;
      memreq_q <= 1'b0;
      busc_q   <= 1'b0;
    end else begin
      state    <= next_state;
      a_q      <= nx_a;
      b_q      <= nx_b;
      c_q      <= nx_c;
      sel_a_q  <= nx_sel_a;
      sel_b_q  <= nx_sel_b;
      sel_c_q  <= nx_sel_c;
      alu_q    <= nx_alu;
      memreq_q <= nx_memreq;
      busc_q   <= nx_busc;
      // op3[4] marks the cc variants; flags arrive active-low.
      if (state == S_EXEC && op3[4])
        psr <= ~{uCONTROL_negative_InLow, uCONTROL_zero_InLow,
                 uCONTROL_overflow_InLow, uCONTROL_carry_InLow};
    end
  end

  // IR load is masked until the ack arrives so a stale BUS_C is never written.
  assign uCONTROL_BUS_CONTROL_C_OutBUS = (state == S_FETCH && !uCONTROL_memack_InHigh) ? C_NONE : c_q;
  // Illegal is decoded from the IR loaded at the ack edge, valid only in DECODE.
  assign uCONTROL_illegal_OutHigh = (state == S_DECODE) && !legal_alu && !is_branch;

  assign uCONTROL_memreq_OutHigh               = memreq_q;
  assign uCONTROL_busCsource_Out               = busc_q;
  assign uCONTROL_BUS_CONTROL_A_OutBUS         = a_q;
  assign uCONTROL_BUS_CONTROL_B_OutBUS         = b_q;
  assign uCONTROL_BUS_SELECTOR_A_Out           = sel_a_q;
  assign uCONTROL_BUS_SELECTOR_B_Out           = sel_b_q;
  assign uCONTROL_BUS_SELECTOR_C_Out           = sel_c_q;
  assign uCONTROL_aluselection_OutBUS          = alu_q;
  assign uCONTROL_decoderclearselection_OutBUS = CLEAR_NONE;
  assign uCONTROL_psr_OutBUS                   = psr;

endmodule

// File: tb/tb_ucontrol_sequencer.sv
// Self-checking bench for ucontrol_sequencer. Each scenario queues per-cycle
// stimulus together with the expected output vector. It then replays the queue
// and compares once per cycle, shortly after each rising edge.
module tb_ucontrol_sequencer;

  localparam logic [3:0] PASSA = 4'd0, ADD = 4'd1, SRL = 4'd5, INC4 = 4'd6, BRADDR = 4'd7;

  // 0x86004002 has op3 = 000000 (add); the cc form sets IR[23].
  localparam logic [31:0] I_ADDCC   = 32'h8680_4002;
  localparam logic [31:0] I_ADD     = 32'h8600_4002;
  localparam logic [31:0] I_SRL     = 32'h8130_0000;
  localparam logic [31:0] I_ADDCC_I = 32'h8680_6002;
  localparam logic [31:0] I_OP3_BAD = 32'h81F8_0000;
  localparam logic [31:0] I_CALL    = 32'h4000_0010;
  localparam logic [31:0] I_BE      = 32'h0280_0004;
  localparam logic [31:0] I_BN      = 32'h0080_0004;
  localparam logic [31:0] I_BA      = 32'h1080_0004;

  // {memreq, busc, A, B, C, selA, selB, selC, alu, clear, illegal, psr}
  typedef logic [35:0] obs_t;
  typedef struct {
    logic        rst;
    logic        ack;
    logic [3:0]  fl_n;
    logic [31:0] ir;
    obs_t        exp;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic [3:0]  fl_n = 4'hF;
  logic [31:0] ir = 32'h0;
  logic        memreq, busc, sel_a, sel_b, sel_c, ill;
  logic [5:0]  a_code, b_code, c_code;
  logic [3:0]  alu, clr, psr;

  int n_assert = 0;
  int n_fail   = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  ucontrol_sequencer dut (
    .uCONTROL_CLOCK_50                     (clk),
    .uCONTROL_RESET_InHigh                 (rst),
    .uCONTROL_Registro_IR_InBUS            (ir),
    .uCONTROL_overflow_InLow               (fl_n[1]),
    .uCONTROL_carry_InLow                  (fl_n[0]),
    .uCONTROL_negative_InLow               (fl_n[3]),
    .uCONTROL_zero_InLow                   (fl_n[2]),
    .uCONTROL_memack_InHigh                (ack),
    .uCONTROL_memreq_OutHigh               (memreq),
    .uCONTROL_busCsource_Out               (busc),
    .uCONTROL_BUS_CONTROL_A_OutBUS         (a_code),
    .uCONTROL_BUS_CONTROL_B_OutBUS         (b_code),
    .uCONTROL_BUS_CONTROL_C_OutBUS         (c_code),
    .uCONTROL_BUS_SELECTOR_A_Out           (sel_a),
    .uCONTROL_BUS_SELECTOR_B_Out           (sel_b),
    .uCONTROL_BUS_SELECTOR_C_Out           (sel_c),
    .uCONTROL_aluselection_OutBUS          (alu),
    .uCONTROL_decoderclearselection_OutBUS (clr),
    .uCONTROL_psr_OutBUS                   (psr),
    .uCONTROL_illegal_OutHigh              (ill)
  );

  function automatic obs_t sample();
    return {memreq, busc, a_code, b_code, c_code, sel_a, sel_b, sel_c, alu, clr, ill, psr};
  endfunction

  function automatic obs_t mk(logic mr, logic bc, logic [5:0] a, logic [5:0] b, logic [5:0] c,
                              logic [2:0] sel, logic [3:0] op, logic il, logic [3:0] p);
    return {mr, bc, a, b, c, sel, op, 4'd15, il, p};
  endfunction

  function automatic obs_t e_idle(logic [3:0] p);               return mk(1'b0, 1'b0, 6'd6, 6'd8, 6'd15, 3'b111, PASSA, 1'b0, p); endfunction
  function automatic obs_t e_fetch(logic k, logic [3:0] p);     return mk(1'b1, 1'b1, 6'd6, 6'd8, k ? 6'd6 : 6'd15, 3'b111, PASSA, 1'b0, p); endfunction
  function automatic obs_t e_dec(logic il, logic [3:0] p);      return mk(1'b0, 1'b0, 6'd6, 6'd8, 6'd15, 3'b111, PASSA, il, p); endfunction
  function automatic obs_t e_exec(logic [3:0] op, logic [3:0] p); return mk(1'b0, 1'b0, 6'd6, 6'd8, 6'd15, 3'b000, op, 1'b0, p); endfunction
  function automatic obs_t e_branch(logic [3:0] p);             return mk(1'b0, 1'b0, 6'd6, 6'd7, 6'd5, 3'b111, BRADDR, 1'b0, p); endfunction
  function automatic obs_t e_pcinc(logic [3:0] p);              return mk(1'b0, 1'b0, 6'd6, 6'd8, 6'd5, 3'b111, INC4, 1'b0, p); endfunction

  task automatic push(logic r, logic k, logic [3:0] f, logic [31:0] i, obs_t e);
    ent_t n;
    n.rst = r; n.ack = k; n.fl_n = f; n.ir = i; n.exp = e;
    sb.push_back(n);
  endtask

  // Reset at start, then reset held 3 cycles while in EXEC of an addcc.
  task automatic test_reset();
    ent_t e; obs_t got; int k = 0;
    push(1, 0, 4'hF, 32'h0, e_idle(4'h0));
    push(1, 0, 4'hF, 32'h0, e_idle(4'h0));
    push(0, 0, 4'hF, 32'h0, e_idle(4'h0));
    push(0, 1, 4'hF, 32'h0, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_dec(0, 4'h0));
    push(1, 0, 4'h0, I_ADDCC, e_exec(ADD, 4'h0));
    push(1, 1, 4'h0, I_ADDCC, e_idle(4'h0));
    push(1, 0, 4'hF, I_ADDCC, e_idle(4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_idle(4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_fetch(0, 4'h0));
    push(0, 1, 4'hF, I_ADDCC, e_fetch(1, 4'h0));
    push(0, 0, 4'h0, I_ADD, e_dec(0, 4'h0));
    push(0, 0, 4'h0, I_ADD, e_exec(ADD, 4'h0));
    push(0, 0, 4'hF, I_ADD, e_pcinc(4'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  // addcc with two wait cycles on memack; N asserted sets PSR to 1000.
  task automatic test_addcc();
    ent_t e; obs_t got; int k = 0;
    push(0, 0, 4'hF, I_ADD, e_fetch(0, 4'h0));
    push(0, 0, 4'hF, I_ADD, e_fetch(0, 4'h0));
    push(0, 1, 4'hF, I_ADD, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_dec(0, 4'h0));
    push(0, 0, 4'b0111, I_ADDCC, e_exec(ADD, 4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_pcinc(4'b1000));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL addcc cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  // Non-cc add and srl leave PSR alone; memack outside FETCH is ignored.
  task automatic test_add();
    ent_t e; obs_t got; int k = 0;
    push(0, 1, 4'hF, I_ADDCC, e_fetch(1, 4'h8));
    push(0, 1, 4'hF, I_ADD, e_dec(0, 4'h8));
    push(0, 1, 4'h0, I_ADD, e_exec(ADD, 4'h8));
    push(0, 1, 4'hF, I_ADD, e_pcinc(4'h8));
    push(0, 1, 4'hF, I_ADD, e_fetch(1, 4'h8));
    push(0, 0, 4'hF, I_SRL, e_dec(0, 4'h8));
    push(0, 0, 4'h0, I_SRL, e_exec(SRL, 4'h8));
    push(0, 0, 4'hF, I_SRL, e_pcinc(4'h8));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL add cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  // be taken after addcc sets Z, then untaken after addcc clears flags.
  task automatic test_branch();
    ent_t e; obs_t got; int k = 0;
    push(0, 1, 4'hF, I_SRL, e_fetch(1, 4'h8));
    push(0, 0, 4'hF, I_ADDCC, e_dec(0, 4'h8));
    push(0, 0, 4'b1011, I_ADDCC, e_exec(ADD, 4'h8));
    push(0, 0, 4'hF, I_ADDCC, e_pcinc(4'b0100));
    push(0, 1, 4'hF, I_ADDCC, e_fetch(1, 4'b0100));
    push(0, 0, 4'hF, I_BE, e_dec(0, 4'b0100));
    push(0, 0, 4'hF, I_BE, e_branch(4'b0100));
    push(0, 1, 4'hF, I_BE, e_fetch(1, 4'b0100));
    push(0, 0, 4'hF, I_ADDCC, e_dec(0, 4'b0100));
    push(0, 0, 4'hF, I_ADDCC, e_exec(ADD, 4'b0100));
    push(0, 0, 4'hF, I_ADDCC, e_pcinc(4'h0));
    push(0, 1, 4'hF, I_ADDCC, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_BE, e_dec(0, 4'h0));
    push(0, 0, 4'hF, I_BE, e_pcinc(4'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL branch cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  // Immediate form, bad op3 and call pulse illegal; bn is never taken but legal.
  task automatic test_illegal();
    ent_t e; obs_t got; int k = 0;
    push(0, 1, 4'hF, I_BE, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_ADDCC_I, e_dec(1, 4'h0));
    push(0, 0, 4'h0, I_ADDCC_I, e_pcinc(4'h0));
    push(0, 1, 4'hF, I_ADDCC_I, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_OP3_BAD, e_dec(1, 4'h0));
    push(0, 0, 4'hF, I_OP3_BAD, e_pcinc(4'h0));
    push(0, 1, 4'hF, I_OP3_BAD, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_CALL, e_dec(1, 4'h0));
    push(0, 0, 4'hF, I_CALL, e_pcinc(4'h0));
    push(0, 1, 4'hF, I_CALL, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_BN, e_dec(0, 4'h0));
    push(0, 0, 4'hF, I_BN, e_pcinc(4'h0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL illegal cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  // ba then addcc with immediate acks: memreq rises at cycles 1, 4 and 8.
  task automatic test_back_to_back();
    ent_t e; obs_t got; int k = 0;
    push(0, 1, 4'hF, I_BN, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_BA, e_dec(0, 4'h0));
    push(0, 0, 4'hF, I_BA, e_branch(4'h0));
    push(0, 1, 4'hF, I_BA, e_fetch(1, 4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_dec(0, 4'h0));
    push(0, 0, 4'b1110, I_ADDCC, e_exec(ADD, 4'h0));
    push(0, 0, 4'hF, I_ADDCC, e_pcinc(4'b0001));
    push(0, 0, 4'hF, I_ADDCC, e_fetch(0, 4'b0001));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk); #1;
      rst = e.rst; ack = e.ack; fl_n = e.fl_n; ir = e.ir;
      #1; got = sample(); n_assert++; k++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h required %h", k, got, e.exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addcc();
    test_add();
    test_branch();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
